decoder_scan_ctrl: RTL and testbench

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

---
 rtl/decoder_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - channel scan controller driving a 3-to-8 decoder
//
// Purpose: steps a 3-bit channel code through the set bits of a captured
// channel mask. Each channel is held for dwell+1 cycles. A scan runs once
// (mode=0) or repeats until stopped (mode=1).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a scan when idle
//   stop       abort the scan in progress
//   mode       0 = single sweep, 1 = continuous
//   mask[7:0]  channel enable mask, bit i enables channel i
//   dwell      cycles to hold each channel, minus one
//   sel[2:0]   channel code to decoder (sel[2]=A, sel[1]=B, sel[0]=C)
//   active     sel is valid, decoder output to be honoured
//   ch_strobe  one-cycle pulse on the first cycle of each channel
//   done       one-cycle pulse at the normal end of a single sweep
//   err        one-cycle pulse when start is accepted with an empty mask

module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               active,
  output logic               ch_strobe,
  output logic               done,
  output logic               err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]         state_q,     state_d;
  logic [7:0]         mask_q,      mask_d;
  logic [DWELL_W-1:0] dwell_q,     dwell_d;
  logic               mode_q,      mode_d;
  logic [DWELL_W-1:0] cnt_q,       cnt_d;
  logic [2:0]         sel_q,       sel_d;
  logic               active_q,    active_d;
  logic               ch_strobe_q, ch_strobe_d;
  logic               done_q,      done_d;
  logic               err_q,       err_d;

  // Lowest set bit of a mask; 0 when the mask is empty.
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next set bit strictly above the current channel in the captured mask.
  logic       nxt_found;
  logic [2:0] nxt_idx;

  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    dwell_d     = dwell_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    active_d    = active_q;
    ch_strobe_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // start together with stop is treated as no request at all.
        if (start && !stop) begin
          if (mask != 8'd0) begin
            state_d     = SCAN;
            mask_d      = mask;
            dwell_d     = dwell;
            mode_d      = mode;
            cnt_d       = dwell;
            sel_d       = lowest_bit(mask);
            active_d    = 1'b1;
            ch_strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          state_d  = IDLE;
          sel_d    = 3'd0;
          active_d = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (nxt_found) begin
          sel_d       = nxt_idx;
          cnt_d       = dwell_q;
          ch_strobe_d = 1'b1;
        end else if (mode_q) begin
          // Wrap with no gap; a single-bit mask reselects the same channel.
          sel_d       = lowest_bit(mask_q);
          cnt_d       = dwell_q;
          ch_strobe_d = 1'b1;
        end else begin
          state_d  = IDLE;
          sel_d    = 3'd0;
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        sel_d    = 3'd0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= 8'd0;
      dwell_q     <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      sel_q       <= 3'd0;
      active_q    <= 1'b0;
      ch_strobe_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      dwell_q     <= dwell_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      active_q    <= active_d;
      ch_strobe_q <= ch_strobe_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign sel       = sel_q;
  assign active    = active_q;
  assign ch_strobe = ch_strobe_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - self-checking bench for decoder_scan_ctrl

module tb_decoder_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       active;
  logic       ch_strobe;
  logic       done;
  logic       err;

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .mask      (mask),
    .dwell     (dwell),
    .sel       (sel),
    .active    (active),
    .ch_strobe (ch_strobe),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       active;
    logic       strobe;
    logic       done;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decoder with inputs A (MSB), B, C; output bit i goes high when ABC == i.
  function automatic logic [7:0] dec38(input logic a, input logic b, input logic c);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) begin
      o[i] = (a == i[2]) && (b == i[1]) && (c == i[0]);
    end
    return o;
  endfunction

  // Model: expected outputs, one entry per cycle, starting with the cycle in
  // which start is still being sampled. Channels are the set mask bits in
  // ascending order, each lasting dwell+1 cycles.
  task automatic push_scan(input logic [7:0] m, input int d, input logic md, input int ncyc);
    int   chans[$];
    exp_t e;
    int   n;
    exp_q.push_back('0);
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    if (chans.size() == 0) begin
      e = '0;
      e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
    if (!md) begin
      foreach (chans[k]) begin
        for (int j = 0; j <= d; j++) begin
          e = '0;
          e.sel = 3'(chans[k]);
          e.active = 1'b1;
          e.strobe = (j == 0);
          exp_q.push_back(e);
        end
      end
      e = '0;
      e.done = 1'b1;
      exp_q.push_back(e);
    end else begin
      n = 0;
      while (n < ncyc) begin
        foreach (chans[k]) begin
          for (int j = 0; j <= d; j++) begin
            if (n < ncyc) begin
              e = '0;
              e.sel = 3'(chans[k]);
              e.active = 1'b1;
              e.strobe = (j == 0);
              exp_q.push_back(e);
              n++;
            end
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin : cmp
    exp_t       e;
    logic [7:0] d;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '0;
      chk("sel", sel, e.sel);
      chk("active", active, e.active);
      chk("ch_strobe", ch_strobe, e.strobe);
      chk("done", done, e.done);
      chk("err", err, e.err);
      chk("strobe_without_active", ch_strobe && !active, 0);
      chk("done_with_err", done && err, 0);
      if (e.active) begin
        d = dec38(sel[2], sel[1], sel[0]);
        chk("dec_onehot", $countones(d), 1);
        chk("dec_bit", d[e.sel], 1);
      end
    end
  end

  task automatic begin_scan(input logic [7:0] m, input int d, input logic md, input int ncyc);
    mask  = m;
    dwell = 8'(d);
    mode  = md;
    start = 1'b1;
    push_scan(m, d, md, ncyc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Continuous scan stopped so that exactly k scan cycles are seen.
  task automatic stop_after(input int k);
    @(posedge clk); #1 start = 1'b0;
    repeat (k - 1) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  logic [2:0] lit_a5 [8];

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    mask = 8'd0;  dwell = 8'd0;
    lit_a5 = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};

    #3;
    chk("rst_sel", sel, 0);
    chk("rst_active", active, 0);
    chk("rst_strobe", ch_strobe, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // stop while idle, then start+stop together: both leave the block idle
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    mask = 8'h0F; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single sweep over 8'b1010_0101 with dwell=1
    begin_scan(8'hA5, 1, 1'b0, 0);
    for (int i = 0; i < 8; i++) chk("model_a5_sel", exp_q[1 + i].sel, lit_a5[i]);
    chk("model_a5_done", exp_q[9].done, 1);
    @(posedge clk); #1 start = 1'b0;
    wait_drain();

    // empty mask: err only
    begin_scan(8'h00, 0, 1'b0, 0);
    @(posedge clk); #1 start = 1'b0;
    wait_drain();

    // full mask, dwell=3; inputs and start toggled mid-scan are ignored
    begin_scan(8'hFF, 3, 1'b0, 0);
    chk("model_ff_len", exp_q.size(), 34);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 mask = 8'h01; dwell = 8'd0; mode = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_drain();

    // continuous 0,7,0,7 with dwell=0; stop while sel=7
    begin_scan(8'h81, 0, 1'b1, 6);
    chk("model_81_last_sel", exp_q[6].sel, 7);
    stop_after(6);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;

    // single-bit mask in continuous mode reselects the channel
    begin_scan(8'h08, 2, 1'b1, 9);
    stop_after(9);
    wait_drain();

    // top channel only, single sweep, dwell=0
    begin_scan(8'h80, 0, 1'b0, 0);
    @(posedge clk); #1 start = 1'b0;
    wait_drain();

    // asynchronous reset mid-scan while sel=4
    begin_scan(8'h18, 2, 1'b1, 5);
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", sel, 0);
    chk("async_rst_active", active, 0);
    chk("async_rst_strobe", ch_strobe, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_err", err, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    wait_drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
